// File: rtl/datamem_pkg.sv
// -----------------------------------------------------------------------------
// datamem_pkg
// Shared definitions for the datamem_sub load/store data memory:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'd3 is illegal)
//   - controller state enum
//   - byte-lane enable, store-data replication and load-extract helpers
// -----------------------------------------------------------------------------
package datamem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Byte-lane write enables for an aligned access of the given size at the given lane.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Right-justified store data copied onto every lane it could land on, so
  // the lane enables alone pick the destination bytes.
  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

  // Shift the addressed lane(s) down to bit 0 and sign- or zero-extend.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/datamem_if.sv
// -----------------------------------------------------------------------------
// datamem_if
// Request/response bus between the execute stage and datamem_sub.
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_we               1 = store, 0 = load
//   req_size             0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned         zero-extend loads when 1
//   req_addr             byte address
//   req_wdata            right-justified store data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            load result (0 for stores and faults), held between responses
//   rsp_err              fault flag, qualified by rsp_valid, held between responses
// Modports: master (requester), slave (memory).
// -----------------------------------------------------------------------------
interface datamem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/datamem_ram.sv
// -----------------------------------------------------------------------------
// datamem_ram
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, per-byte write enable and
// registered read. A read happens on an enabled cycle with no byte written;
// the read register holds its value otherwise.
//   clk       clock
//   en_i      access enable
//   we_i      byte write enables (0 = read)
//   addr_i    word index
//   wdata_i   write data
//   rdata_o   registered read data
// -----------------------------------------------------------------------------
module datamem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [3:0]          we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the control
  // path around it is reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      if (we_i == 4'b0000) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_sub.sv
// -----------------------------------------------------------------------------
// datamem_sub
// Byte-addressable data memory for the load/store path with a single
// outstanding request/response transaction.
//   clk   clock, all state on rising edge
//   rst   asynchronous active-low reset
//   bus   datamem_if.slave request/response port
// Parameters: DATA_W (fixed 32), ADDR_W (word-index width), RD_LAT (1..4).
// Build option: define DATAMEM_CLEAR_EN to zero the whole array after reset
// (one word per cycle) before the first request is accepted.
// -----------------------------------------------------------------------------
module datamem_sub
  import datamem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  datamem_if.slave bus
);

  // RWAIT occupies RD_LAT-1 cycles; the counter is loaded with RD_LAT-2 and
  // the exit happens on the cycle it reads zero.
  localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e              state_q;
  logic [1:0]          lat_cnt_q;
  logic [1:0]          size_q;
  logic [1:0]          lane_q;
  logic                uns_q;
  logic                is_load_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rdata_hold_q;
`ifdef DATAMEM_CLEAR_EN
  logic [ADDR_W-1:0]   clr_cnt_q;
`endif

  // Request decode.
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic                out_of_range;
  logic                misaligned;
  logic                fault;
  logic                accept;

  assign word_idx     = bus.req_addr[ADDR_W+1:2];
  assign lane         = bus.req_addr[1:0];
  assign out_of_range = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
  assign misaligned   = (bus.req_size == SZ_HALF && lane[0]) ||
                        (bus.req_size == SZ_WORD && lane != 2'd0) ||
                        (bus.req_size == 2'd3);
  assign fault        = out_of_range || misaligned;
  assign accept       = bus.req_valid && (state_q == ST_IDLE);

  // RAM port steering.
  logic                ram_en;
  logic [3:0]          ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch is never inferred.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = word_idx;
    ram_wdata = store_replicate(bus.req_size, bus.req_wdata);
`ifdef DATAMEM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 4'b1111;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end
`endif
    if (accept && !fault) begin
      ram_en = 1'b1;
      ram_we = bus.req_we ? lane_enable(bus.req_size, lane) : 4'b0000;
    end
  end

  datamem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Response data: during the RESP cycle it is taken straight from the RAM
  // read register (so RD_LAT = 1 needs no extra stage); afterwards a copy is
  // held so the value survives later RAM reads until the next response.
  logic [31:0] rsp_now;
  assign rsp_now = is_load_q ? load_extract(ram_rdata, size_q, lane_q, uns_q) : 32'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef DATAMEM_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      lat_cnt_q    <= 2'd0;
      size_q       <= SZ_BYTE;
      lane_q       <= 2'd0;
      uns_q        <= 1'b0;
      is_load_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rdata_hold_q <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (rsp_valid_q) rdata_hold_q <= rsp_now;

      case (state_q)
`ifdef DATAMEM_CLEAR_EN
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_q <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (bus.req_valid) begin
            size_q    <= bus.req_size;
            lane_q    <= lane;
            uns_q     <= bus.req_unsigned;
            is_load_q <= !bus.req_we && !fault;
            if (fault || bus.req_we) begin
              // Stores commit on this edge; faults never touch the array.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= fault;
            end else if (RD_LAT > 1) begin
              state_q   <= ST_RWAIT;
              lat_cnt_q <= LAT_INIT;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
            end
          end
        end
        ST_RWAIT: begin
          if (lat_cnt_q == 2'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_valid_q ? rsp_now : rdata_hold_q;

endmodule

// File: tb/tb_datamem_sub.sv
// -----------------------------------------------------------------------------
// tb_datamem_sub
// Directed bench for datamem_sub. Two instances share clock, reset and request
// fields: dut_a with RD_LAT = 1 and dut_b with RD_LAT = 3 (both ADDR_W = 16).
// Each transaction checks response latency, data, error flag, that req_ready
// stays low while the transaction is in flight, that rsp_valid is a one-cycle
// pulse, and that rsp_rdata holds after the pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_datamem_sub;
  import datamem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  datamem_if bus_a ();
  datamem_if bus_b ();

  logic        va = 1'b0;
  logic        vb = 1'b0;
  logic        t_we = 1'b0;
  logic [1:0]  t_size = SZ_WORD;
  logic        t_uns = 1'b0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;

  assign bus_a.req_valid    = va;
  assign bus_a.req_we       = t_we;
  assign bus_a.req_size     = t_size;
  assign bus_a.req_unsigned = t_uns;
  assign bus_a.req_addr     = t_addr;
  assign bus_a.req_wdata    = t_wdata;
  assign bus_b.req_valid    = vb;
  assign bus_b.req_we       = t_we;
  assign bus_b.req_size     = t_size;
  assign bus_b.req_unsigned = t_uns;
  assign bus_b.req_addr     = t_addr;
  assign bus_b.req_wdata    = t_wdata;

  datamem_sub #(.DATA_W(32), .ADDR_W(16), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  datamem_sub #(.DATA_W(32), .ADDR_W(16), .RD_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction
  function automatic logic vld(input int sel);
    return (sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
  endfunction
  function automatic logic errf(input int sel);
    return (sel == 0) ? bus_a.rsp_err : bus_b.rsp_err;
  endfunction

  // Wait (bounded) for req_ready, present one request, then watch the response.
  task automatic xact(input string tag, input int sel, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int   guard;
    int   lat;
    logic seen;
    logic busy_ready;
    logic [31:0] got_rdata;
    logic got_err;
    guard = 0;
    @(negedge clk);
    while (!rdy(sel) && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, {31'd0, rdy(sel)}, 32'd1);
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    if (sel == 0) va = 1'b1; else vb = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0; vb = 1'b0;
    lat = 0; seen = 1'b0; busy_ready = 1'b0;
    got_rdata = 32'd0; got_err = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (rdy(sel)) busy_ready = 1'b1;
      if (vld(sel)) begin
        seen = 1'b1;
        lat = k;
        got_rdata = rdat(sel);
        got_err = errf(sel);
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, busy_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, vld(sel)}, 32'd0);
    check({tag, "_hold"}, rdat(sel), exp_rdata);
  endtask

  initial begin
    int   cnt;
    logic seen;

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
`ifdef DATAMEM_CLEAR_EN
    check("rst_ready", {31'd0, bus_a.req_ready}, 32'd0);
`else
    check("rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
`endif
    check("rst_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("rst_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_err",   {31'd0, bus_a.rsp_err}, 32'd0);
    rst = 1'b1;

`ifdef DATAMEM_CLEAR_EN
    cnt = 0;
    while (!bus_a.req_ready && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    check("clear_cycles", cnt, 32'd65536);
`else
    // Contents are undefined without the sweep; zero the words used below.
    xact("init_w0", 0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    xact("init_w1", 0, 1'b1, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1);
`endif

    //   tag           sel we    size     uns   addr           wdata          exp_rdata      err   lat
    xact("ld_w4_zero",  0, 1'b0, SZ_WORD, 1'b0, 32'h4,         32'h0,         32'h00000000, 1'b0, 1);
    xact("st_w4_ones",  0, 1'b1, SZ_WORD, 1'b0, 32'h4,         32'hFFFFFFFF,  32'h00000000, 1'b0, 1);
    xact("ld_b5_s",     0, 1'b0, SZ_BYTE, 1'b0, 32'h5,         32'h0,         32'hFFFFFFFF, 1'b0, 1);
    xact("ld_b5_u",     0, 1'b0, SZ_BYTE, 1'b1, 32'h5,         32'h0,         32'h000000FF, 1'b0, 1);
    xact("st_h6",       0, 1'b1, SZ_HALF, 1'b0, 32'h6,         32'h00001234,  32'h00000000, 1'b0, 1);
    xact("ld_w4_mix",   0, 1'b0, SZ_WORD, 1'b0, 32'h4,         32'h0,         32'h1234FFFF, 1'b0, 1);
    xact("ld_h4_s",     0, 1'b0, SZ_HALF, 1'b0, 32'h4,         32'h0,         32'hFFFFFFFF, 1'b0, 1);
    xact("ld_h6_u",     0, 1'b0, SZ_HALF, 1'b1, 32'h6,         32'h0,         32'h00001234, 1'b0, 1);
    xact("ld_b7_s",     0, 1'b0, SZ_BYTE, 1'b0, 32'h7,         32'h0,         32'h00000012, 1'b0, 1);
    xact("ld_b6_u",     0, 1'b0, SZ_BYTE, 1'b1, 32'h6,         32'h0,         32'h00000034, 1'b0, 1);
    xact("st_b1",       0, 1'b1, SZ_BYTE, 1'b0, 32'h1,         32'h00000080,  32'h00000000, 1'b0, 1);
    xact("ld_b1_s",     0, 1'b0, SZ_BYTE, 1'b0, 32'h1,         32'h0,         32'hFFFFFF80, 1'b0, 1);
    xact("ld_w0",       0, 1'b0, SZ_WORD, 1'b0, 32'h0,         32'h0,         32'h00008000, 1'b0, 1);

    // Faults: memory must stay untouched.
    xact("f_ld_w2",     0, 1'b0, SZ_WORD, 1'b0, 32'h2,         32'h0,         32'h00000000, 1'b1, 1);
    xact("f_st_h3",     0, 1'b1, SZ_HALF, 1'b0, 32'h3,         32'h0000ABCD,  32'h00000000, 1'b1, 1);
    xact("f_range",     0, 1'b1, SZ_WORD, 1'b0, 32'h00040000,  32'hDEADBEEF,  32'h00000000, 1'b1, 1);
    xact("f_size3_st",  0, 1'b1, 2'd3,    1'b0, 32'h0,         32'hCAFEF00D,  32'h00000000, 1'b1, 1);
    xact("f_size3_ld",  0, 1'b0, 2'd3,    1'b0, 32'h4,         32'h0,         32'h00000000, 1'b1, 1);
    xact("ld_w0_keep",  0, 1'b0, SZ_WORD, 1'b0, 32'h0,         32'h0,         32'h00008000, 1'b0, 1);
    xact("ld_w4_keep",  0, 1'b0, SZ_WORD, 1'b0, 32'h4,         32'h0,         32'h1234FFFF, 1'b0, 1);

    // RD_LAT = 3 instance.
    xact("b_st_w10",    1, 1'b1, SZ_WORD, 1'b0, 32'h10,        32'h89ABCDEF,  32'h00000000, 1'b0, 1);
    xact("b_ld_w10",    1, 1'b0, SZ_WORD, 1'b0, 32'h10,        32'h0,         32'h89ABCDEF, 1'b0, 3);
    xact("b_ld_b13_s",  1, 1'b0, SZ_BYTE, 1'b0, 32'h13,        32'h0,         32'hFFFFFF89, 1'b0, 3);
    xact("b_ld_h12_u",  1, 1'b0, SZ_HALF, 1'b1, 32'h12,        32'h0,         32'h000089AB, 1'b0, 3);
    xact("b_f_w11",     1, 1'b0, SZ_WORD, 1'b0, 32'h11,        32'h0,         32'h00000000, 1'b1, 1);

    // Reset during RWAIT: the pending response must never appear.
    @(negedge clk);
    check("rw_ready", {31'd0, bus_b.req_ready}, 32'd1);
    t_we = 1'b0; t_size = SZ_WORD; t_uns = 1'b0; t_addr = 32'h10; t_wdata = 32'h0;
    vb = 1'b1;
    @(posedge clk);
    #1;
    vb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rw_valid_in_rst", {31'd0, bus_b.rsp_valid}, 32'd0);
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus_b.rsp_valid) seen = 1'b1;
    end
    check("rw_no_pulse", {31'd0, seen}, 32'd0);

`ifdef DATAMEM_CLEAR_EN
    xact("b_after_rst", 1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0, 3);
`else
    xact("b_after_rst", 1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h89ABCDEF, 1'b0, 3);
    xact("a_after_rst", 0, 1'b0, SZ_WORD, 1'b0, 32'h4,  32'h0, 32'h1234FFFF, 1'b0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
